// File: rtl/tap_capture_ctrl.sv
// Purpose: arms on one of three datapath taps, drops cfg_skip valid beats, then forwards cfg_len beats with an index.
// Latency: a selected beat sampled at cycle c appears on the capture port at c+1. All outputs are registered.
// Backpressure: none. The capture port has no ready signal, and beats that arrive outside CAPT are dropped.
module tap_capture_ctrl #(
    parameter int BUS_NUM    = 4,
    parameter int DOUT_WIDTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_en_0,
    input  logic [BUS_NUM*DOUT_WIDTH-1:0] din_real_0,
    input  logic [BUS_NUM*DOUT_WIDTH-1:0] din_imag_0,
    input  logic                          din_en_1,
    input  logic [BUS_NUM*DOUT_WIDTH-1:0] din_real_1,
    input  logic [BUS_NUM*DOUT_WIDTH-1:0] din_imag_1,
    input  logic                          din_en_2,
    input  logic [BUS_NUM*DOUT_WIDTH-1:0] din_real_2,
    input  logic [BUS_NUM*DOUT_WIDTH-1:0] din_imag_2,
    input  logic [1:0]                    cfg_sel,
    input  logic [LEN_W-1:0]              cfg_skip,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic                          arm,
    input  logic                          abort,
    output logic                          cap_en,
    output logic [BUS_NUM*DOUT_WIDTH-1:0] cap_real,
    output logic [BUS_NUM*DOUT_WIDTH-1:0] cap_imag,
    output logic [1:0]                    cap_src,
    output logic [LEN_W-1:0]              cap_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err_sel
);
    localparam int W = BUS_NUM * DOUT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [LEN_W-1:0] skip_q, skip_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             cap_en_q, cap_en_d;
    logic [W-1:0]     cap_real_q, cap_real_d;
    logic [W-1:0]     cap_imag_q, cap_imag_d;
    logic [1:0]       cap_src_q, cap_src_d;
    logic [LEN_W-1:0] cap_idx_q, cap_idx_d;
    logic             busy_q, done_q, err_q, err_d;

    logic             tap_en;
    logic [W-1:0]     tap_real, tap_imag;

    // Route the latched tap to the capture path. Sel 3 can never be latched.
    always_comb begin
        tap_en   = 1'b0;
        tap_real = '0;
        tap_imag = '0;
        case (sel_q)
            2'd0:    begin tap_en = din_en_0; tap_real = din_real_0; tap_imag = din_imag_0; end
            2'd1:    begin tap_en = din_en_1; tap_real = din_real_1; tap_imag = din_imag_1; end
            2'd2:    begin tap_en = din_en_2; tap_real = din_real_2; tap_imag = din_imag_2; end
            default: begin tap_en = 1'b0;     tap_real = '0;         tap_imag = '0;         end
        endcase
    end

    // Next-state logic. Abort takes priority over everything, and arm is only honoured while idle or done.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        skip_d     = skip_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        cap_en_d   = 1'b0;
        cap_real_d = cap_real_q;
        cap_imag_d = cap_imag_q;
        cap_src_d  = cap_src_q;
        cap_idx_d  = cap_idx_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        if (cfg_sel == 2'd3) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            sel_d  = cfg_sel;
                            skip_d = cfg_skip;
                            len_d  = cfg_len;
                            cnt_d  = '0;
                            err_d  = 1'b0;
                            if (cfg_skip != '0)     state_d = S_SKIP;
                            else if (cfg_len != '0) state_d = S_CAPT;
                            else                    state_d = S_DONE;
                        end
                    end
                end
                S_SKIP: begin
                    if (tap_en) begin
                        skip_d = skip_q - LEN_W'(1);
                        // The beat that exhausts the skip count is itself discarded.
                        if (skip_q == LEN_W'(1))
                            state_d = (len_q == '0) ? S_DONE : S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (tap_en) begin
                        cap_en_d   = 1'b1;
                        cap_real_d = tap_real;
                        cap_imag_d = tap_imag;
                        cap_src_d  = sel_q;
                        cap_idx_d  = cnt_q;
                        cnt_d      = cnt_q + LEN_W'(1);
                        // Compare against len-1 so that len = 2^LEN_W-1 finishes before the count wraps.
                        if (cnt_q == len_q - LEN_W'(1))
                            state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs. busy and done come from the next state, so they line up with cap_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            skip_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_real_q <= '0;
            cap_imag_q <= '0;
            cap_src_q  <= '0;
            cap_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            skip_q     <= skip_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            cap_en_q   <= cap_en_d;
            cap_real_q <= cap_real_d;
            cap_imag_q <= cap_imag_d;
            cap_src_q  <= cap_src_d;
            cap_idx_q  <= cap_idx_d;
            busy_q     <= (state_d == S_SKIP) || (state_d == S_CAPT);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign cap_en   = cap_en_q;
    assign cap_real = cap_real_q;
    assign cap_imag = cap_imag_q;
    assign cap_src  = cap_src_q;
    assign cap_idx  = cap_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_sel  = err_q;

endmodule

// File: tb/tb_tap_capture_ctrl.sv
// Bench for tap_capture_ctrl: directed scenarios followed by a random run.
// The reference model counts selected beats since the last accepted arm.
// Each output is compared every cycle, one time unit after the rising edge.
module tb_tap_capture_ctrl;
    localparam int BUS_NUM    = 4;
    localparam int DOUT_WIDTH = 16;
    localparam int LEN_W      = 16;
    localparam int W          = BUS_NUM * DOUT_WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             tap_en [3];
    logic [W-1:0]     tap_re [3];
    logic [W-1:0]     tap_im [3];
    logic [1:0]       cfg_sel;
    logic [LEN_W-1:0] cfg_skip, cfg_len;
    logic             arm, abort;
    logic             cap_en, busy, done, err_sel;
    logic [W-1:0]     cap_real, cap_imag;
    logic [1:0]       cap_src;
    logic [LEN_W-1:0] cap_idx;

    tap_capture_ctrl #(.BUS_NUM(BUS_NUM), .DOUT_WIDTH(DOUT_WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .din_en_0(tap_en[0]), .din_real_0(tap_re[0]), .din_imag_0(tap_im[0]),
        .din_en_1(tap_en[1]), .din_real_1(tap_re[1]), .din_imag_1(tap_im[1]),
        .din_en_2(tap_en[2]), .din_real_2(tap_re[2]), .din_imag_2(tap_im[2]),
        .cfg_sel(cfg_sel), .cfg_skip(cfg_skip), .cfg_len(cfg_len),
        .arm(arm), .abort(abort),
        .cap_en(cap_en), .cap_real(cap_real), .cap_imag(cap_imag),
        .cap_src(cap_src), .cap_idx(cap_idx),
        .busy(busy), .done(done), .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_cap = 0;
    int en_mode [3];
    bit fixed_data = 1'b0;

    // Reference model state: the latched configuration and the number of selected beats seen since arm.
    bit           m_act, m_err, m_cap;
    int           m_sel, m_skip, m_len, m_seen;
    logic [W-1:0] m_re, m_im;
    int           m_idx, m_src;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_err = 0; m_cap = 0; m_sel = 0; m_skip = 0; m_len = 0; m_seen = 0;
        m_re = '0; m_im = '0; m_idx = 0; m_src = 0;
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = m_act && (m_seen < m_skip + m_len);
        chk("cap_en",   W'(cap_en),   W'(m_cap));
        chk("cap_real", cap_real,     m_re);
        chk("cap_imag", cap_imag,     m_im);
        chk("cap_idx",  W'(cap_idx),  W'(m_idx));
        chk("cap_src",  W'(cap_src),  W'(m_src));
        chk("busy",     W'(busy),     W'(exp_busy));
        chk("done",     W'(done),     W'(m_act && !exp_busy));
        chk("err_sel",  W'(err_sel),  W'(m_err));
    endtask

    // Apply the capture rules to the inputs sampled at this edge.
    task automatic model_step();
        bit busy_now;
        busy_now = m_act && (m_seen < m_skip + m_len);
        m_cap = 0;
        if (abort) begin
            m_act = 0;
        end else if (arm && !busy_now) begin
            if (cfg_sel == 2'd3) begin
                m_err = 1; m_act = 0;
            end else begin
                m_act = 1; m_err = 0; m_seen = 0;
                m_sel = int'(cfg_sel); m_skip = int'(cfg_skip); m_len = int'(cfg_len);
            end
        end else if (busy_now && tap_en[m_sel]) begin
            m_seen++;
            if (m_seen > m_skip) begin
                m_cap = 1;
                m_re  = tap_re[m_sel];
                m_im  = tap_im[m_sel];
                m_idx = m_seen - m_skip - 1;
                m_src = m_sel;
            end
        end
    endtask

    task automatic gen_taps();
        for (int t = 0; t < 3; t++) begin
            case (en_mode[t])
                0:       tap_en[t] = 1'b0;
                1:       tap_en[t] = 1'b1;
                2:       tap_en[t] = (cyc % 2 == 0);
                default: tap_en[t] = 1'($urandom_range(0, 1));
            endcase
            if (fixed_data) begin
                tap_re[t] = {BUS_NUM{16'h8000}};
                tap_im[t] = {BUS_NUM{16'h7FFF}};
            end else begin
                tap_re[t] = {$urandom, $urandom};
                tap_im[t] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic cycle();
        gen_taps();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_all();
        if (cap_en) n_cap++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic modes(input int a, input int b, input int c);
        en_mode[0] = a; en_mode[1] = b; en_mode[2] = c;
    endtask

    task automatic do_arm(input logic [1:0] s, input int sk, input int ln);
        cfg_sel = s; cfg_skip = LEN_W'(sk); cfg_len = LEN_W'(ln); arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0;
        cfg_sel = '0; cfg_skip = '0; cfg_len = '0;
        modes(0, 0, 0);
        gen_taps();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // T1: tap 1, no skip, four beats on back-to-back valid input.
        modes(0, 1, 0); n_cap = 0;
        do_arm(2'd1, 0, 4); run(6);
        chk("t1_count", W'(n_cap), W'(4));

        // T2: tap 0 valid on alternate cycles, skip three of its beats, capture two.
        modes(2, 1, 1); n_cap = 0;
        do_arm(2'd0, 3, 2); run(14);
        chk("t2_count", W'(n_cap), W'(2));

        // T3: an illegal select flags an error; a legal re-arm clears it.
        modes(1, 1, 1); n_cap = 0;
        do_arm(2'd3, 0, 5); run(2);
        chk("t3_err", W'(err_sel), W'(1));
        chk("t3_none", W'(n_cap), W'(0));
        do_arm(2'd2, 0, 1); run(3);
        chk("t3_count", W'(n_cap), W'(1));

        // T4: a re-arm while busy is ignored, then abort after three beats.
        modes(0, 0, 1); n_cap = 0;
        do_arm(2'd2, 0, 8);
        do_arm(2'd1, 0, 3);
        run(2);
        do_abort();
        run(3);
        chk("t4_count", W'(n_cap), W'(3));

        // T5: zero length finishes at once; abort beats a simultaneous arm; skip>0 with len=0.
        modes(1, 1, 1); n_cap = 0;
        do_arm(2'd0, 0, 0);
        chk("t5_done", W'(done), W'(1));
        run(2);
        cfg_sel = 2'd1; cfg_len = LEN_W'(4); arm = 1'b1; abort = 1'b1;
        cycle();
        arm = 1'b0; abort = 1'b0;
        chk("t5_abort_done", W'(done), W'(0));
        run(3);
        do_arm(2'd1, 2, 0); run(4);
        chk("t5_count", W'(n_cap), W'(0));

        // Maximum length: index must climb cleanly, then abort.
        modes(0, 0, 3);
        do_arm(2'd2, 1, 16'hFFFF); run(30); do_abort();

        // T6: reset in the middle of a capture of extreme lane values, then a clean re-run.
        fixed_data = 1'b1; modes(1, 0, 0); n_cap = 0;
        do_arm(2'd0, 1, 10); run(4);
        do_reset();
        n_cap = 0;
        do_arm(2'd0, 0, 3); run(5);
        chk("t6_count", W'(n_cap), W'(3));
        fixed_data = 1'b0;

        // Random traffic on all taps with random arms, aborts and configurations.
        for (int i = 0; i < 600; i++) begin
            modes(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            arm      = ($urandom_range(0, 99) < 12);
            abort    = ($urandom_range(0, 99) < 3);
            cfg_sel  = 2'($urandom_range(0, 3));
            cfg_skip = LEN_W'($urandom_range(0, 4));
            cfg_len  = LEN_W'($urandom_range(0, 6));
            cycle();
            arm = 1'b0; abort = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
